control_unit: RTL and testbench

Hardwired Moore control sequencer for the Mini-SRC Datapath. It replaces the hand-stepped T-state strobes used by the instruction benches.
- Runs fetch (T0–T2), then an opcode-specific execute sequence of up to five steps (T3–T7).
- Returns to T0 after each instruction, or parks in HALT.
- Sits between the IR and every Datapath control input.

---
 rtl/control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore control sequencer for the Mini-SRC datapath. Every
// instruction runs a three-step fetch (T0-T2), then an opcode-specific execute
// sequence of up to five steps (T3-T7). After that the unit returns to T0, or
// it parks in HALT.
//
// Ports
//   clock      system clock, rising edge
//   clear      asynchronous active-low reset (state -> RST, all strobes 0)
//   ir         instruction register contents; opcode = ir[IR_W-1 -: OP_W]
//   con_ff     branch condition flip-flop, used only in the branch T6 step
//   resume     leaves HALT when high at a clock edge; ignored elsewhere
//   *out       bus-drive strobes
//   *in        register-load strobes
//   Gra/b/c    register-field selects
//   IncPC, Read, Write, JAL_flag   PC increment, memory control, R15 write
//   alu_op     ALU function select (add unless a step says otherwise)
//   halted     high only while in HALT
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int OP_W = 5,
  parameter int IR_W = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            resume,
  output logic            PCout,
  output logic            MDRout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            BAout,
  output logic            Cout,
  output logic            Rout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            HIin,
  output logic            LOin,
  output logic            OutPortin,
  output logic            Rin,
  output logic            CONin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            JAL_flag,
  output logic [OP_W-1:0] alu_op,
  output logic            halted
);

  localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(13);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_IN   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_OUT  = OP_W'(23);
  localparam logic [OP_W-1:0] OP_MFHI = OP_W'(24);
  localparam logic [OP_W-1:0] OP_MFLO = OP_W'(25);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state;

  logic [OP_W-1:0] opcode;
  assign opcode = ir[IR_W-1 -: OP_W];

  // Operand fields are decoded by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = &{1'b0, ir[IR_W-OP_W-1:0]};

  // Opcode classes; nop and the undefined codes fall out as "none of these".
  logic op_alu, op_imm, op_ldi, op_ld, op_st, op_muldiv, op_negnot;
  logic op_br, op_jr, op_jal, op_in, op_out, op_mfhi, op_mflo, op_halt;

  always_comb begin
    op_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    op_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    op_ldi    = (opcode == OP_LDI);
    op_ld     = (opcode == OP_LD);
    op_st     = (opcode == OP_ST);
    op_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    op_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
    op_br     = (opcode == OP_BR);
    op_jr     = (opcode == OP_JR);
    op_jal    = (opcode == OP_JAL);
    op_in     = (opcode == OP_IN);
    op_out    = (opcode == OP_OUT);
    op_mfhi   = (opcode == OP_MFHI);
    op_mflo   = (opcode == OP_MFLO);
    op_halt   = (opcode == OP_HALT);
  end

  // Sequencing. The opcode is only consulted from T3 on, because the IR is
  // loaded by the edge that ends T2.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST: state <= S_T0;
        S_T0:  state <= S_T1;
        S_T1:  state <= S_T2;
        S_T2:  state <= S_T3;
        S_T3: begin
          if (op_halt)
            state <= S_HALT;
          else if (op_alu || op_imm || op_ldi || op_ld || op_st || op_muldiv ||
                   op_negnot || op_br || op_jal)
            state <= S_T4;
          else
            state <= S_T0;
        end
        S_T4:  state <= op_negnot ? S_T0 : S_T5;
        S_T5:  state <= (op_ld || op_st || op_muldiv || op_br) ? S_T6 : S_T0;
        S_T6:  state <= (op_ld || op_st) ? S_T7 : S_T0;
        S_T7:  state <= S_T0;
        S_HALT: begin
          if (resume)
            state <= S_T0;
        end
        default: state <= S_RST;
      endcase
    end
  end

  // Strobe decode from (state, opcode). Because it is combinational off the
  // state register, an asynchronous clear drops every strobe at once.
  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; BAout = 1'b0;
    Cout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    OutPortin = 1'b0; Rin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; JAL_flag = 1'b0;
    halted = 1'b0;
    alu_op = OP_ADD;

    case (state)
      S_RST: alu_op = '0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (op_alu || op_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (op_ldi || op_ld || op_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (op_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (op_negnot) begin
          Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = opcode;
        end else if (op_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (op_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (op_jal) begin
          PCout = 1'b1; Zlowin = 1'b1;
        end else if (op_in) begin
          InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_out) begin
          Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
        end else if (op_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_mflo) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T4: begin
        if (op_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = opcode;
        end else if (op_imm) begin
          Cout = 1'b1; Zlowin = 1'b1;
          // Immediate forms reuse the register-form ALU codes.
          if (opcode == OP_ANDI)
            alu_op = OP_AND;
          else if (opcode == OP_ORI)
            alu_op = OP_OR;
          else
            alu_op = OP_ADD;
        end else if (op_ldi || op_ld || op_st) begin
          Cout = 1'b1; Zlowin = 1'b1;
        end else if (op_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
          alu_op = opcode;
        end else if (op_negnot) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else if (op_jal) begin
          Zlowout = 1'b1; JAL_flag = 1'b1;
        end
      end
      S_T5: begin
        if (op_alu || op_imm || op_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_ld || op_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (op_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (op_br) begin
          Cout = 1'b1; Zlowin = 1'b1;
        end else if (op_jal) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end
      end
      S_T6: begin
        if (op_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (op_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (op_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (op_br) begin
          // Branch target is taken only when the condition holds right now.
          Zlowout = 1'b1; PCin = con_ff;
        end
      end
      S_T7: begin
        if (op_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_st) begin
          Write = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: alu_op = '0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Randomized bench for control_unit. A reference model built from the
// instruction step tables and latency table predicts, for each cycle of an
// instruction, the full strobe vector and alu_op. Directed cases cover reset,
// add, jal, both branch outcomes, ld with a mid-instruction clear and halt.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic        resume = 1'b0;

  logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, BAout, Cout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin, Rin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write, JAL_flag, halted;
  logic [4:0] alu_op;

  int checks = 0;
  int errors = 0;

  control_unit #(.OP_W(5), .IR_W(32)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .resume(resume),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .BAout(BAout),
    .Cout(Cout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .Rin(Rin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write), .JAL_flag(JAL_flag),
    .alu_op(alu_op), .halted(halted)
  );

  always #5 clock = ~clock;

  // Observed strobes packed into one vector, bit positions match the masks.
  logic [29:0] obs;
  assign obs = {halted, JAL_flag, Write, Read, IncPC, Grc, Grb, Gra,
                CONin, Rin, OutPortin, LOin, HIin, Zhighin, Zlowin, Yin,
                IRin, MDRin, MARin, PCin,
                Rout, Cout, BAout, InPortout, LOout, HIout, Zhighout, Zlowout,
                MDRout, PCout};

  localparam logic [29:0] M_PCOUT     = 30'd1 << 0;
  localparam logic [29:0] M_MDROUT    = 30'd1 << 1;
  localparam logic [29:0] M_ZLOWOUT   = 30'd1 << 2;
  localparam logic [29:0] M_ZHIGHOUT  = 30'd1 << 3;
  localparam logic [29:0] M_HIOUT     = 30'd1 << 4;
  localparam logic [29:0] M_LOOUT     = 30'd1 << 5;
  localparam logic [29:0] M_INPORTOUT = 30'd1 << 6;
  localparam logic [29:0] M_BAOUT     = 30'd1 << 7;
  localparam logic [29:0] M_COUT      = 30'd1 << 8;
  localparam logic [29:0] M_ROUT      = 30'd1 << 9;
  localparam logic [29:0] M_PCIN      = 30'd1 << 10;
  localparam logic [29:0] M_MARIN     = 30'd1 << 11;
  localparam logic [29:0] M_MDRIN     = 30'd1 << 12;
  localparam logic [29:0] M_IRIN      = 30'd1 << 13;
  localparam logic [29:0] M_YIN       = 30'd1 << 14;
  localparam logic [29:0] M_ZLOWIN    = 30'd1 << 15;
  localparam logic [29:0] M_ZHIGHIN   = 30'd1 << 16;
  localparam logic [29:0] M_HIIN      = 30'd1 << 17;
  localparam logic [29:0] M_LOIN      = 30'd1 << 18;
  localparam logic [29:0] M_OUTPORTIN = 30'd1 << 19;
  localparam logic [29:0] M_RIN       = 30'd1 << 20;
  localparam logic [29:0] M_CONIN     = 30'd1 << 21;
  localparam logic [29:0] M_GRA       = 30'd1 << 22;
  localparam logic [29:0] M_GRB       = 30'd1 << 23;
  localparam logic [29:0] M_GRC       = 30'd1 << 24;
  localparam logic [29:0] M_INCPC     = 30'd1 << 25;
  localparam logic [29:0] M_READ      = 30'd1 << 26;
  localparam logic [29:0] M_WRITE     = 30'd1 << 27;
  localparam logic [29:0] M_JAL       = 30'd1 << 28;
  localparam logic [29:0] M_HALTED    = 30'd1 << 29;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    int unsigned r;
    r = $urandom;
    return r[0];
  endfunction

  // Total clocks per instruction including fetch (halt counts T0-T3).
  function automatic int latency(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o == 0 || o == 2) return 8;
    if (o == 19 || o == 15 || o == 16) return 7;
    if ((o >= 1 && o <= 14) || o == 21) return 6;
    if (o == 17 || o == 18) return 5;
    return 4;
  endfunction

  // Expected strobes and alu_op for step k (0 = T0) of instruction op.
  function automatic void exp_step(input logic [4:0] op, input int k, input logic con,
                                   output logic [29:0] v, output logic [4:0] a);
    logic [29:0] seq [0:4];
    logic [4:0]  al  [0:4];
    int o;
    o = int'(op);
    for (int i = 0; i < 5; i++) begin
      seq[i] = '0;
      al[i]  = 5'd3;
    end
    if (o >= 3 && o <= 11) begin
      seq[0] = M_GRB | M_ROUT | M_YIN;
      seq[1] = M_GRC | M_ROUT | M_ZLOWIN;  al[1] = op;
      seq[2] = M_ZLOWOUT | M_GRA | M_RIN;
    end else if (o >= 12 && o <= 14) begin
      seq[0] = M_GRB | M_ROUT | M_YIN;
      seq[1] = M_COUT | M_ZLOWIN;
      al[1]  = (o == 12) ? 5'd3 : ((o == 13) ? 5'd5 : 5'd6);
      seq[2] = M_ZLOWOUT | M_GRA | M_RIN;
    end else if (o <= 2) begin
      seq[0] = M_GRB | M_BAOUT | M_YIN;
      seq[1] = M_COUT | M_ZLOWIN;
      if (o == 1) begin
        seq[2] = M_ZLOWOUT | M_GRA | M_RIN;
      end else begin
        seq[2] = M_ZLOWOUT | M_MARIN;
        if (o == 0) begin
          seq[3] = M_READ | M_MDRIN;
          seq[4] = M_MDROUT | M_GRA | M_RIN;
        end else begin
          seq[3] = M_GRA | M_ROUT | M_MDRIN;
          seq[4] = M_WRITE;
        end
      end
    end else if (o == 15 || o == 16) begin
      seq[0] = M_GRA | M_ROUT | M_YIN;
      seq[1] = M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN;  al[1] = op;
      seq[2] = M_ZLOWOUT | M_LOIN;
      seq[3] = M_ZHIGHOUT | M_HIIN;
    end else if (o == 17 || o == 18) begin
      seq[0] = M_GRB | M_ROUT | M_ZLOWIN;  al[0] = op;
      seq[1] = M_ZLOWOUT | M_GRA | M_RIN;
    end else if (o == 19) begin
      seq[0] = M_GRA | M_ROUT | M_CONIN;
      seq[1] = M_PCOUT | M_YIN;
      seq[2] = M_COUT | M_ZLOWIN;
      seq[3] = M_ZLOWOUT | (con ? M_PCIN : 30'd0);
    end else if (o == 20) begin
      seq[0] = M_GRA | M_ROUT | M_PCIN;
    end else if (o == 21) begin
      seq[0] = M_PCOUT | M_ZLOWIN;
      seq[1] = M_ZLOWOUT | M_JAL;
      seq[2] = M_GRA | M_ROUT | M_PCIN;
    end else if (o == 22) begin
      seq[0] = M_INPORTOUT | M_GRA | M_RIN;
    end else if (o == 23) begin
      seq[0] = M_GRA | M_ROUT | M_OUTPORTIN;
    end else if (o == 24) begin
      seq[0] = M_HIOUT | M_GRA | M_RIN;
    end else if (o == 25) begin
      seq[0] = M_LOOUT | M_GRA | M_RIN;
    end
    a = 5'd3;
    case (k)
      0: v = M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
      1: v = M_READ | M_MDRIN;
      2: v = M_MDROUT | M_IRIN;
      default: begin
        v = seq[k-3];
        a = al[k-3];
      end
    endcase
  endfunction

  int instr_no = 0;

  // Run one instruction starting from the edge that enters T0.
  // abort_at >= 0 pulses clear during that step; con_mode < 0 randomizes con_ff;
  // hold_n is the number of HALT cycles with resume = 0 (halt only).
  task automatic run_instr(input logic [31:0] instr, input int abort_at,
                           input int con_mode, input int hold_n);
    logic [4:0]  op;
    logic [29:0] ev;
    logic [4:0]  ea;
    int          lat;
    bit          aborted;
    op = instr[31:27];
    lat = latency(op);
    aborted = 1'b0;
    $display("instr %0d ir=%h op=%0d lat=%0d abort_at=%0d", instr_no, instr, op, lat, abort_at);
    instr_no++;
    for (int k = 0; k < lat && !aborted; k++) begin
      @(posedge clock);
      #1;
      ir = (k >= 3) ? instr : $urandom;
      con_ff = (con_mode < 0) ? rbit() : (con_mode != 0);
      resume = rbit();
      @(negedge clock);
      exp_step(op, k, con_ff, ev, ea);
      check_val($sformatf("op%0d_T%0d_strobes", op, k), {2'b0, obs}, {2'b0, ev});
      check_val($sformatf("op%0d_T%0d_alu", op, k), {27'b0, alu_op}, {27'b0, ea});
      if (k == abort_at) begin
        #1 clear = 1'b0;
        #1;
        check_val("abort_now_strobes", {2'b0, obs}, 32'h0);
        check_val("abort_now_alu", {27'b0, alu_op}, 32'h0);
        @(posedge clock);
        #1;
        check_val("abort_hold_strobes", {2'b0, obs}, 32'h0);
        clear = 1'b1;
        aborted = 1'b1;
      end
    end
    if (!aborted && op == 5'd27) begin
      for (int h = 0; h <= hold_n; h++) begin
        @(posedge clock);
        #1;
        resume = (h == hold_n);
        con_ff = rbit();
        ir = $urandom;
        @(negedge clock);
        check_val($sformatf("halt_cycle%0d_strobes", h), {2'b0, obs}, {2'b0, M_HALTED});
        check_val("halt_alu", {27'b0, alu_op}, 32'd3);
      end
    end
  endtask

  initial begin
    logic [31:0] instr;
    int unsigned r;
    int          op_i;
    int          ab;

    // Reset held for two cycles: everything zero.
    clear = 1'b0;
    ir = $urandom;
    resume = 1'b1;
    con_ff = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_val("reset_strobes", {2'b0, obs}, 32'h0);
      check_val("reset_alu", {27'b0, alu_op}, 32'h0);
    end
    @(posedge clock);
    #1 clear = 1'b1;
    @(negedge clock);
    check_val("rst_state_strobes", {2'b0, obs}, 32'h0);

    // Directed cases.
    run_instr(32'h18918000, -1, -1, 0);  // add
    run_instr(32'hAB000000, -1, -1, 0);  // jal R6
    run_instr(32'h98000000, -1, 0, 0);   // br, not taken
    run_instr(32'h98000000, -1, 1, 0);   // br, taken
    run_instr(32'h00000000, 6, -1, 0);   // ld, clear during T6
    run_instr(32'h00000000, -1, -1, 0);  // ld, complete
    run_instr(32'hD8000000, -1, -1, 10); // halt, 10 idle cycles then resume
    run_instr(32'h10000000, -1, -1, 0);  // st

    // Every opcode once.
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      instr = {5'(i), r[26:0]};
      run_instr(instr, -1, -1, 2);
    end

    // Random instruction stream with occasional aborts.
    for (int i = 0; i < 120; i++) begin
      r = $urandom;
      instr = r;
      op_i = int'(instr[31:27]);
      ab = -1;
      if ($urandom_range(15) == 0)
        ab = int'($urandom_range(latency(instr[31:27]) - 1));
      run_instr(instr, ab, -1, op_i % 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
